// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game sequencer.
// States, period width, BCD digit type and the score increment helper.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int PERIOD_W = 4;

  typedef logic [3:0] bcd_t;

  localparam int DEF_INIT_PERIOD     = 8;
  localparam int DEF_MIN_PERIOD      = 2;
  localparam int DEF_SPEEDUP_APPLES  = 4;
  localparam int DEF_DEBOUNCE_FRAMES = 3;
  localparam int DEF_CLEAR_FRAMES    = 2;

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    bcd_t tens;
    bcd_t ones;
    tens = s[7:4];
    ones = s[3:0];
    if (s == 8'h99)
      return s;
    if (ones == 4'd9)
      return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/snake_game_ctrl_debounce.sv
// Start button conditioning: 2-FF synchronizer, frame-sampled
// stability counter and a one-cycle press pulse on a debounced rise.
module btn_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic frame_tick,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync <= 2'b00;
    else
      sync <= {sync[0], btn};
  end

  // Accept a new level after enough consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (frame_tick) begin
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_FRAMES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
          press <= sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: IDLE/CLEAR/RUN/OVER flow, movement tick,
// BCD score and score-driven speed-up.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int INIT_PERIOD     = DEF_INIT_PERIOD,
  parameter int MIN_PERIOD      = DEF_MIN_PERIOD,
  parameter int SPEEDUP_APPLES  = DEF_SPEEDUP_APPLES,
  parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
  parameter int CLEAR_FRAMES    = DEF_CLEAR_FRAMES
) (
  input  logic       VGA_clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       apple_eaten,
  input  logic       game_over,
  output logic       start,
  output logic       update,
  output logic [7:0] score_bcd,
  output logic [1:0] state_o
);

  localparam int AW =
    (SPEEDUP_APPLES > 1) ? $clog2(SPEEDUP_APPLES) : 1;
  localparam int CCW = $clog2(CLEAR_FRAMES + 1);

  game_state_t         state;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] frame_cnt;
  logic [AW-1:0]       apple_cnt;
  logic [CCW-1:0]      clear_cnt;
  logic                press;

  btn_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_btn (
    .clk       (VGA_clk),
    .rst_n     (rst_n),
    .btn       (start_btn),
    .frame_tick(frame_tick),
    .press     (press)
  );

  assign state_o = state;

  // Game flow, movement timing, score and speed in one register set.
  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start     <= 1'b0;
      update    <= 1'b0;
      score_bcd <= 8'h00;
      period    <= PERIOD_W'(INIT_PERIOD);
      frame_cnt <= '0;
      apple_cnt <= '0;
      clear_cnt <= '0;
    end else begin
      update <= 1'b0;
      unique case (state)
        IDLE: begin
          if (press) begin
            state     <= CLEAR;
            clear_cnt <= '0;
          end
        end
        CLEAR: begin
          score_bcd <= 8'h00;
          period    <= PERIOD_W'(INIT_PERIOD);
          frame_cnt <= '0;
          apple_cnt <= '0;
          if (frame_tick) begin
            if (clear_cnt == CCW'(CLEAR_FRAMES - 1)) begin
              state     <= RUN;
              start     <= 1'b1;
              clear_cnt <= '0;
            end else begin
              clear_cnt <= clear_cnt + CCW'(1);
            end
          end
        end
        RUN: begin
          if (frame_tick) begin
            if (frame_cnt >= period - PERIOD_W'(1)) begin
              frame_cnt <= '0;
              update    <= !game_over;
            end else begin
              frame_cnt <= frame_cnt + PERIOD_W'(1);
            end
          end
          if (apple_eaten) begin
            score_bcd <= bcd_inc(score_bcd);
            if (apple_cnt == AW'(SPEEDUP_APPLES - 1)) begin
              apple_cnt <= '0;
              if (period > PERIOD_W'(MIN_PERIOD))
                period <= period - PERIOD_W'(1);
            end else begin
              apple_cnt <= apple_cnt + AW'(1);
            end
          end
          if (game_over)
            state <= OVER;
        end
        OVER: begin
          if (press) begin
            state     <= CLEAR;
            start     <= 1'b0;
            clear_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule
